// File: rtl/img_pkg.sv
// Shared image constants and FSM state encoding for the frame-buffer
// readback path (img_rd_tx) and the UART image loader (img_rx_wr).
package img_pkg;

  localparam int IMG_W      = 256;
  localparam int IMG_H      = 256;
  localparam int PIX_W      = 16;
  localparam int IMG_ADDR_W = 16;

  // Readback FSM encoding, kept as plain constants for legacy tools
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND_B0 = 3'd3;
  localparam logic [2:0] ST_WAIT_B0 = 3'd4;
  localparam logic [2:0] ST_SEND_B1 = 3'd5;
  localparam logic [2:0] ST_WAIT_B1 = 3'd6;

  // Select the high or low byte of an RGB565 pixel
  function automatic logic [7:0] pix_byte(input logic [PIX_W-1:0] pix,
                                          input logic sel_hi);
    logic [7:0] b;
    if (sel_hi) begin
      b = pix[15:8];
    end else begin
      b = pix[7:0];
    end
    return b;
  endfunction

endpackage

// File: rtl/img_rd_tx_if.sv
// Control, RAM read port and byte-transmitter handshake of the readback block.
// master = the readback engine, slave = its environment (RAM, UART, host ctrl).
interface img_rd_tx_if
  import img_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W
) ();

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              ram_rden;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [PIX_W-1:0]  ram_rddata;
  logic [7:0]        tx_data;
  logic              send_en;
  logic              tx_done;

  modport master (
    input  start, abort, ram_rddata, tx_done,
    output busy, done, ram_rden, ram_rdaddr, tx_data, send_en
  );

  modport slave (
    output start, abort, ram_rddata, tx_done,
    input  busy, done, ram_rden, ram_rdaddr, tx_data, send_en
  );

endinterface

// File: rtl/img_rd_tx.sv
// Frame-buffer readback: walks the frame RAM from address 0 to IMG_PIXELS-1
// and hands each RGB565 pixel to the UART byte transmitter as two bytes.
// Each byte waits for the transmitter's tx_done before the next one is
// issued, so throughput is set entirely by the UART.
module img_rd_tx
  import img_pkg::*;
#(
  parameter int IMG_PIXELS = IMG_W * IMG_H,
  parameter int ADDR_W     = IMG_ADDR_W,
  parameter int RD_LAT     = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic         Clk,
  input  logic         Reset,
  img_rd_tx_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        lat_cnt_r;
  logic [PIX_W-1:0]  pix_r;
  logic [7:0]        tx_data_r;
  logic              send_en_r;
  logic              rden_r;
  logic              busy_r;
  logic              done_r;
  logic [7:0]        byte0_s;
  logic [7:0]        byte1_s;

  // Byte order on the wire for the held pixel
  always_comb begin
    byte0_s = pix_byte(pix_r, MSB_FIRST);
    byte1_s = pix_byte(pix_r, !MSB_FIRST);
  end

  // Readback FSM with address counter, read-latency counter and pixel hold
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      addr_r    <= '0;
      lat_cnt_r <= 2'd0;
      pix_r     <= '0;
      tx_data_r <= 8'd0;
      send_en_r <= 1'b0;
      rden_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      rden_r    <= 1'b0;
      send_en_r <= 1'b0;
      done_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // busy is held through the done cycle so a start there is ignored
          if (done_r) begin
            busy_r <= 1'b0;
          end else if (bus.start) begin
            state_r <= ST_RD_REQ;
            busy_r  <= 1'b1;
            addr_r  <= '0;
            rden_r  <= 1'b1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RD_REQ: begin
          lat_cnt_r <= 2'd0;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_cnt_r == LAT_LAST) begin
            pix_r   <= bus.ram_rddata;
            state_r <= ST_SEND_B0;
          end else begin
            lat_cnt_r <= lat_cnt_r + 2'd1;
          end
        end
        ST_SEND_B0: begin
          tx_data_r <= byte0_s;
          send_en_r <= 1'b1;
          state_r   <= ST_WAIT_B0;
        end
        ST_WAIT_B0: begin
          if (bus.tx_done) begin
            if (bus.abort) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_SEND_B1;
            end
          end else begin
            state_r <= ST_WAIT_B0;
          end
        end
        ST_SEND_B1: begin
          tx_data_r <= byte1_s;
          send_en_r <= 1'b1;
          state_r   <= ST_WAIT_B1;
        end
        ST_WAIT_B1: begin
          if (bus.tx_done) begin
            if (bus.abort) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (addr_r == LAST_ADDR) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
              addr_r  <= '0;
            end else begin
              addr_r  <= addr_r + ADDR_W'(1);
              rden_r  <= 1'b1;
              state_r <= ST_RD_REQ;
            end
          end else begin
            state_r <= ST_WAIT_B1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ram_rden   = rden_r;
  assign bus.ram_rdaddr = addr_r;
  assign bus.tx_data    = tx_data_r;
  assign bus.send_en    = send_en_r;

endmodule
